intersection_arbiter: RTL and testbench

Phase scheduler that shares the intersection between three requesters: main-road traffic (default owner), side-road traffic (`sensor`), and pedestrians (`button_walk`). It grants right-of-way in timed phases, enforces minimum green, yellow and all-red clearance, and alternates priority when side and walk requests compete. It drives the main, side and walk lamp outputs directly. An internal prescaler provides the phase time base.

---
 rtl/traffic_pkg.sv | 35 +++
 rtl/tick_gen.sv | 28 ++
 rtl/intersection_arbiter.sv | 123 ++++++++++++
 tb/tb_intersection_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase and target types for the intersection arbiter.
package traffic_pkg;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_IN   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    WALK        = 3'd5,
    ALLRED_OUT  = 3'd6
  } phase_t;

  typedef enum logic {
    TGT_SIDE = 1'b0,
    TGT_WALK = 1'b1
  } target_t;

  // Packed as {main, side, walk}.
  function automatic logic [6:0] lamps_of(phase_t p);
    case (p)
      MAIN_GREEN:  lamps_of = {LAMP_G, LAMP_R, 1'b0};
      MAIN_YELLOW: lamps_of = {LAMP_Y, LAMP_R, 1'b0};
      SIDE_GREEN:  lamps_of = {LAMP_R, LAMP_G, 1'b0};
      SIDE_YELLOW: lamps_of = {LAMP_R, LAMP_Y, 1'b0};
      WALK:        lamps_of = {LAMP_R, LAMP_R, 1'b1};
      default:     lamps_of = {LAMP_R, LAMP_R, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Phase time-base prescaler: one-cycle tick every TICK_DIV clocks, realigned by restart.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_arbiter.sv
// Timed phase scheduler sharing an intersection between main road, side road and pedestrians.
// Lamps are registered from the next state so they switch on the same edge as the phase.
module intersection_arbiter
  import traffic_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int T_MIN_GREEN = 6,
  parameter int T_EXT       = 3,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 3,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor,
  input  logic       button_walk,
  output logic [2:0] light_main,
  output logic [2:0] light_side,
  output logic       light_walk,
  output logic       walk_pending,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] D_MG  = CNT_W'(T_MIN_GREEN);
  localparam logic [CNT_W-1:0] D_EXT = CNT_W'(T_EXT);
  localparam logic [CNT_W-1:0] D_Y   = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] D_AR  = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] D_W   = CNT_W'(T_WALK);

  phase_t           state, nxt;
  target_t          target;
  logic [CNT_W-1:0] cnt, dur;
  logic             tick, done, moving, ext_go, ext_used;
  logic             both, prio, pick_walk;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (moving),
    .tick    (tick)
  );

  always_comb begin
    dur = D_AR;
    case (state)
      MAIN_GREEN:              dur = D_MG;
      MAIN_YELLOW, SIDE_YELLOW: dur = D_Y;
      SIDE_GREEN:              dur = ext_used ? D_EXT : D_MG;
      WALK:                    dur = D_W;
      default:                 dur = D_AR;
    endcase
  end

  // >= lets the saturated main-green counter keep exiting on any later tick.
  assign done      = tick && (cnt >= dur - 1'b1);
  assign pick_walk = walk_pending && (!sensor || !prio);
  assign ext_go    = (state == SIDE_GREEN) && done && sensor && !ext_used;
  assign moving    = (nxt != state);

  always_comb begin
    nxt = state;
    case (state)
      MAIN_GREEN:  if (done && (walk_pending || sensor)) nxt = MAIN_YELLOW;
      MAIN_YELLOW: if (done) nxt = ALLRED_IN;
      ALLRED_IN:   if (done) nxt = (target == TGT_WALK) ? WALK : SIDE_GREEN;
      SIDE_GREEN:  if (done && (ext_used || !sensor)) nxt = SIDE_YELLOW;
      SIDE_YELLOW: if (done) nxt = ALLRED_OUT;
      WALK:        if (done) nxt = ALLRED_OUT;
      ALLRED_OUT:  if (done) nxt = MAIN_GREEN;
      default:     nxt = MAIN_GREEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= MAIN_GREEN;
      cnt          <= '0;
      ext_used     <= 1'b0;
      target       <= TGT_SIDE;
      both         <= 1'b0;
      prio         <= 1'b0;
      walk_pending <= 1'b0;
      light_main   <= LAMP_G;
      light_side   <= LAMP_R;
      light_walk   <= 1'b0;
      phase        <= 3'd0;
    end else begin
      state <= nxt;
      {light_main, light_side, light_walk} <= lamps_of(nxt);
      phase <= nxt;

      if (moving || ext_go) begin
        cnt <= '0;
      end else if (tick && !(state == MAIN_GREEN && cnt == D_MG)) begin
        cnt <= cnt + 1'b1;
      end

      if (moving) begin
        ext_used <= 1'b0;
      end else if (ext_go) begin
        ext_used <= 1'b1;
      end

      if (state == MAIN_GREEN && moving) begin
        target <= pick_walk ? TGT_WALK : TGT_SIDE;
        both   <= walk_pending && sensor;
      end

      if (state == ALLRED_IN && moving && both) begin
        prio <= ~prio;
      end

      // Entering WALK clears the request even if the button is held that cycle.
      if (nxt == WALK && state != WALK) begin
        walk_pending <= 1'b0;
      end else if (button_walk && state != WALK) begin
        walk_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_intersection_arbiter.sv
// Directed bench: expected phase transitions are queued per scenario and popped as the phase changes.
module tb_intersection_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor = 1'b0;
  logic       button_walk = 1'b0;
  logic [2:0] light_main, light_side, phase;
  logic       light_walk, walk_pending;

  intersection_arbiter #(
    .TICK_DIV(4), .T_MIN_GREEN(6), .T_EXT(3), .T_YELLOW(2),
    .T_ALLRED(1), .T_WALK(3), .CNT_W(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor       (sensor),
    .button_walk  (button_walk),
    .light_main   (light_main),
    .light_side   (light_side),
    .light_walk   (light_walk),
    .walk_pending (walk_pending),
    .phase        (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] ph;
  } ev_t;

  ev_t        sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [2:0] prev_ph = 3'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [6:0] exp_lamps(input logic [2:0] p);
    case (p)
      3'd0:    return {3'b001, 3'b100, 1'b0};
      3'd1:    return {3'b010, 3'b100, 1'b0};
      3'd3:    return {3'b100, 3'b001, 1'b0};
      3'd4:    return {3'b100, 3'b010, 1'b0};
      3'd5:    return {3'b100, 3'b100, 1'b1};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic expect_at(input int c, input logic [2:0] p);
    sb.push_back('{c, p});
  endtask

  // One clock; sample 1 time unit after the edge, then check transitions and lamps.
  task automatic step();
    ev_t ev;
    logic road_conflict;
    @(posedge clk);
    #1;
    cyc++;
    if (phase !== prev_ph) begin
      chk("unexpected_transition", sb.size(), (sb.size() > 0) ? sb.size() : 1);
      if (sb.size() > 0) begin
        ev = sb.pop_front();
        chk("trans_cycle", cyc, ev.cyc);
        chk("trans_phase", {29'd0, phase}, {29'd0, ev.ph});
      end
      prev_ph = phase;
    end
    chk("lamps", {25'd0, light_main, light_side, light_walk}, {25'd0, exp_lamps(phase)});
    road_conflict = (light_main != 3'b100 && light_side != 3'b100) ||
                    (light_walk && (light_main != 3'b100 || light_side != 3'b100));
    chk("lamp_invariant", {31'd0, road_conflict}, 32'd0);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic press();
    button_walk = 1'b1;
    step();
    button_walk = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sensor = 1'b0;
    button_walk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    sb.delete();
    prev_ph = 3'd0;
    chk("rst_phase", {29'd0, phase}, 32'd0);
    chk("rst_lamps", {25'd0, light_main, light_side, light_walk}, {25'd0, 3'b001, 3'b100, 1'b0});
    chk("rst_walk_pending", {31'd0, walk_pending}, 32'd0);
  endtask

  initial begin
    // Idle: main rests forever.
    do_reset();
    run_to(200);
    chk("idle_phase", {29'd0, phase}, 32'd0);
    chk("idle_drained", sb.size(), 0);

    // Side request with one extension.
    do_reset();
    sensor = 1'b1;
    expect_at(24, 3'd1); expect_at(32, 3'd2); expect_at(36, 3'd3);
    expect_at(72, 3'd4); expect_at(80, 3'd6); expect_at(84, 3'd0);
    run_to(65);
    chk("side_extended", {29'd0, phase}, 32'd3);
    run_to(90);
    chk("side_drained", sb.size(), 0);

    // Walk only.
    do_reset();
    expect_at(24, 3'd1); expect_at(32, 3'd2); expect_at(36, 3'd5);
    expect_at(48, 3'd6); expect_at(52, 3'd0);
    run_to(3);
    press();
    chk("walk_latched", {31'd0, walk_pending}, 32'd1);
    run_to(36);
    chk("walk_cleared", {31'd0, walk_pending}, 32'd0);
    chk("walk_lamp_on", {31'd0, light_walk}, 32'd1);
    run_to(47);
    chk("walk_lamp_last", {31'd0, light_walk}, 32'd1);
    run_to(48);
    chk("walk_lamp_off", {31'd0, light_walk}, 32'd0);
    run_to(60);
    chk("walk_drained", sb.size(), 0);

    // Contention: walk first, then side, then walk again as prio alternates.
    do_reset();
    sensor = 1'b1;
    expect_at(24, 3'd1);  expect_at(32, 3'd2);  expect_at(36, 3'd5);
    expect_at(48, 3'd6);  expect_at(52, 3'd0);  expect_at(76, 3'd1);
    expect_at(84, 3'd2);  expect_at(88, 3'd3);  expect_at(112, 3'd4);
    expect_at(120, 3'd6); expect_at(124, 3'd0); expect_at(148, 3'd1);
    expect_at(156, 3'd2); expect_at(160, 3'd5);
    run_to(5);
    press();
    run_to(40);
    press();
    chk("press_in_walk_ignored", {31'd0, walk_pending}, 32'd0);
    run_to(55);
    press();
    chk("second_press_latched", {31'd0, walk_pending}, 32'd1);
    run_to(100);
    sensor = 1'b0;
    run_to(130);
    sensor = 1'b1;
    run_to(159);
    chk("pending_before_walk", {31'd0, walk_pending}, 32'd1);
    run_to(160);
    chk("pending_cleared_walk", {31'd0, walk_pending}, 32'd0);
    run_to(165);
    chk("contention_drained", sb.size(), 0);

    // Reset mid side-green: outputs return without a clock edge.
    do_reset();
    sensor = 1'b1;
    expect_at(24, 3'd1); expect_at(32, 3'd2); expect_at(36, 3'd3);
    run_to(40);
    press();
    run_to(45);
    chk("mid_phase_side", {29'd0, phase}, 32'd3);
    chk("mid_pending", {31'd0, walk_pending}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_lamps", {25'd0, light_main, light_side, light_walk}, {25'd0, 3'b001, 3'b100, 1'b0});
    chk("async_rst_pending", {31'd0, walk_pending}, 32'd0);
    chk("async_rst_phase", {29'd0, phase}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
